// File: rtl/freq_pkg.sv
// Shared constants and state encoding for the frequency divider.
// Both the RTL and its testbench import this package.
package freq_pkg;

  localparam int unsigned DEF_DIVIDEND = 50_000_000;
  localparam int unsigned DEF_WIDTH    = 32;

  // The iteration counter only has to reach DEF_WIDTH-1.
  localparam int unsigned CNT_W = $clog2(DEF_WIDTH);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/freq_divider.sv
// Sequential restoring divider: computes DIVIDEND / divisor, one quotient bit
// per cycle, MSB first. The frequency is published WIDTH+1 cycles after start.
module freq_divider
  import freq_pkg::*;
#(
  parameter int unsigned DIVIDEND = DEF_DIVIDEND,
  parameter int unsigned WIDTH    = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_err
);

  localparam logic [WIDTH-1:0] DIVIDEND_W = WIDTH'(DIVIDEND);
  localparam logic [CNT_W-1:0] LAST_ITER  = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] div_q,   div_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [WIDTH-1:0] prem_q,  prem_d;
  logic [WIDTH-1:0] quot_q,  quot_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic             err_q,   err_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;

  // The partial remainder stays below the divisor, so the shifted trial value
  // fits in WIDTH+1 bits and the sign of the difference is the compare result.
  assign trial = {prem_q, work_q[WIDTH-1]};
  assign diff  = trial - {1'b0, div_q};
  assign fits  = ~diff[WIDTH];

  always_comb begin
    // NOTE: every signal assigned below gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    work_d  = work_q;
    prem_d  = prem_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CALC;
          cnt_d   = '0;
          div_d   = divisor;
          work_d  = DIVIDEND_W;
          prem_d  = '0;
          busy_d  = 1'b1;
        end
      end
      ST_CALC: begin
        prem_d = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        work_d = {work_q[WIDTH-2:0], fits};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // A zero divisor naturally yields all-ones and the full dividend.
        state_d = ST_IDLE;
        quot_d  = work_q;
        rem_d   = prem_q;
        err_d   = (div_q == '0);
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      work_q  <= '0;
      prem_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      work_q  <= work_d;
      prem_q  <= prem_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_err   = err_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_freq_divider.sv
// Testbench for freq_divider: a cycle model pushes expected results into a
// scoreboard on each accepted start; the monitor pops them on done.
module tb_freq_divider;
  import freq_pkg::*;

  localparam int unsigned W   = DEF_WIDTH;
  localparam logic [63:0] DVD = 64'(DEF_DIVIDEND);

  typedef struct {
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         err;
    int unsigned  due;
  } exp_t;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         start   = 1'b0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_err;

  freq_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_err   (div_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sb[$];
  int unsigned done_log[$];
  int unsigned cyc   = 0;
  int unsigned m_cnt = 0;
  logic [W-1:0] last_quot = '0;
  logic [W-1:0] last_rem  = '0;
  logic         last_err  = 1'b0;
  exp_t         mon_e;
  logic         due_now;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] d, input int unsigned due);
    exp_t e;
    e.due = due;
    if (d == '0) begin
      e.quot = '1;
      e.rem  = W'(DVD);
      e.err  = 1'b1;
    end else begin
      e.quot = W'(DVD / 64'(d));
      e.rem  = W'(DVD % 64'(d));
      e.err  = 1'b0;
    end
    return e;
  endfunction

  // Cycle model: accepts start only when idle, stays busy WIDTH+1 edges.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_cnt = 0;
      sb.delete();
      last_quot = '0;
      last_rem  = '0;
      last_err  = 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        sb.push_back(model(divisor, cyc + W + 1));
        m_cnt = W + 1;
      end
    end else begin
      m_cnt--;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      due_now = (sb.size() > 0) && (sb[0].due == cyc);
      check("done", 64'(done), 64'(due_now));
      check("busy", 64'(busy), 64'(m_cnt > 0));
      if (due_now) begin
        mon_e = sb.pop_front();
        check("quotient",  64'(quotient),  64'(mon_e.quot));
        check("remainder", 64'(remainder), 64'(mon_e.rem));
        check("div_err",   64'(div_err),   64'(mon_e.err));
        last_quot = mon_e.quot;
        last_rem  = mon_e.rem;
        last_err  = mon_e.err;
        done_log.push_back(cyc);
      end else begin
        check("quot_hold", 64'(quotient),  64'(last_quot));
        check("rem_hold",  64'(remainder), 64'(last_rem));
        check("err_hold",  64'(div_err),   64'(last_err));
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_cnt == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", 64'(ok), 64'd1);
    @(negedge clk);
  endtask

  task automatic run_div(input logic [W-1:0] d);
    @(negedge clk);
    divisor = d;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_div(32'd50_000);
    check("q_50000", 64'(quotient), 64'd1000);
    check("r_50000", 64'(remainder), 64'd0);
    check("e_50000", 64'(div_err), 64'd0);

    run_div(32'd7);
    check("q_7", 64'(quotient), 64'd7_142_857);
    check("r_7", 64'(remainder), 64'd1);

    run_div(32'd1);
    check("q_1", 64'(quotient), 64'd50_000_000);

    run_div(32'd0);
    check("q_0", 64'(quotient), 64'hFFFF_FFFF);
    check("r_0", 64'(remainder), 64'd50_000_000);
    check("e_0", 64'(div_err), 64'd1);

    run_div(32'd50);
    check("q_50", 64'(quotient), 64'd1_000_000);
    check("e_50", 64'(div_err), 64'd0);

    run_div(32'd60_000_000);
    check("q_big", 64'(quotient), 64'd0);
    check("r_big", 64'(remainder), 64'd50_000_000);
    run_div(32'hFFFF_FFFF);
    run_div(32'd50_000_000);
    run_div(32'd50_000_001);

    // Second start during CALC must be ignored.
    n0 = done_log.size();
    @(negedge clk);
    divisor = 32'd100;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    repeat (9) @(negedge clk);
    divisor = 32'd9;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    check("ignore_q", 64'(quotient), 64'd500_000);
    check("ignore_ndone", 64'(done_log.size() - n0), 64'd1);

    // Divisor changes after acceptance must not matter.
    @(negedge clk);
    divisor = 32'd50_000;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    divisor = 32'd3;
    wait_idle();
    check("latched_q", 64'(quotient), 64'd1000);

    // start held high: back-to-back every WIDTH+2 cycles.
    n0 = done_log.size();
    @(negedge clk);
    divisor = 32'd1000;
    start   = 1'b1;
    repeat (3 * (W + 2) + 2) @(negedge clk);
    start   = 1'b0;
    wait_idle();
    check("b2b_count_ge3", 64'(done_log.size() - n0 >= 3), 64'd1);
    for (int i = n0 + 1; i < done_log.size(); i++) begin
      check("b2b_gap", 64'(done_log[i] - done_log[i-1]), 64'(W + 2));
    end

    // Reset in the middle of CALC aborts without a done pulse.
    @(negedge clk);
    divisor = 32'd50_000;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_quot", 64'(quotient), 64'd0);
    check("abort_rem", 64'(remainder), 64'd0);
    check("abort_err", 64'(div_err), 64'd0);
    n0 = done_log.size();
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(done_log.size() - n0), 64'd0);
    run_div(32'd50_000);
    check("after_abort_q", 64'(quotient), 64'd1000);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst_n   = 1'b0;
    start   = 1'b1;
    divisor = 32'd5;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    check("rst_prio_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("rst_prio_busy2", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
